// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired-zero x0 and an integrated
// RAW/WAW issue scoreboard. Optional write-to-read bypass: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NREAD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  iss_rd_en,
  input  logic [NREAD-1:0]      iss_src_en,
  output logic                  iss_stall,
  output logic [NREGS-1:0]      busy,
  output logic [AW:0]           pending_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [NREAD-1:0] raw;
  logic             wb_hit, waw, accept;

  assign wb_hit = wb_we && (wb_addr != '0);

  always_comb begin : read_and_raw
    rd_data = '0;
    raw     = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (wb_addr == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wb_data;
        end
        raw[i] = iss_src_en[i] && busy_q[rd_addr[i*AW +: AW]] &&
                 !(wb_hit && (wb_addr == rd_addr[i*AW +: AW]));
`else
        raw[i] = iss_src_en[i] && busy_q[rd_addr[i*AW +: AW]];
`endif
      end
    end
  end

  // A same-cycle writeback always releases a WAW, with or without bypass.
  assign waw = iss_rd_en && (iss_rd != '0) && busy_q[iss_rd] &&
               !(wb_we && (wb_addr == iss_rd));

  // Issue handshake: an instruction is taken on a rising edge where
  // iss_valid=1 and iss_stall=0; while stalled, issue must hold it steady.
  assign iss_stall = iss_valid && ((|raw) || waw);
  assign accept    = iss_valid && !iss_stall && iss_rd_en && (iss_rd != '0);

  always_comb begin : busy_next
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[wb_addr] = 1'b0;
    end
    // Set after clear so a same-cycle release and reservation leaves it busy.
    if (accept) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wb_hit) begin
        regs_q[wb_addr] <= wb_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the RV32I core, successor to the fixed 32x32 two-port bank.
- Adds a configurable number of read ports, hardwired-zero x0 and posedge writes.
- Adds an integrated scoreboard that tracks in-flight destination registers and raises an issue stall on RAW and WAW hazards.
- Sits between decode/issue, which reads operands and reserves rd, and writeback, which writes results and releases rd.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREGS), register address width.
- NREAD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- wb_we  in  1  writeback write enable.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  XLEN  writeback data.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- iss_valid  in  1  issue stage presents an instruction.
- iss_rd  in  AW  destination the instruction will write.
- iss_rd_en  in  1  instruction writes a destination.
- iss_src_en  in  NREAD  per-port flag: operand i is actually used.
- iss_stall  out  1  combinational; 1 = instruction not accepted this cycle.
- busy  out  NREGS  scoreboard bit per register, registered.
- pending_cnt  out  AW+1  number of set busy bits, registered.

Behaviour:
- Reset (rst==0 at a rising edge):
  - all registers = 0, busy = 0, pending_cnt = 0.
  - Reset overrides any write or issue in the same cycle.
  - Reset mid-operation discards all reservations.
- Write: at posedge, if wb_we && wb_addr!=0, reg[wb_addr] <= wb_data. Writes to x0 are ignored.
- Read: combinational.
  - rd_data[i] = 0 when rd_addr[i]==0; otherwise reg[rd_addr[i]], subject to bypass (see Optional Feature).
  - Any number of ports may read the same address.
- Writeback release: wb_we && wb_addr!=0 clears busy[wb_addr] at posedge.
- Hazard detection, per port i: raw_i = iss_src_en[i] && rd_addr[i]!=0 && busy[rd_addr[i]] && !(bypass && wb_we && wb_addr==rd_addr[i]).
- WAW hazard: waw = iss_rd_en && iss_rd!=0 && busy[iss_rd] && !(wb_we && wb_addr==iss_rd).
- iss_stall = iss_valid && (any raw_i || waw). When iss_valid==0, iss_stall = 0.
- Reservation: accept = iss_valid && !iss_stall && iss_rd_en && iss_rd!=0. On accept, busy[iss_rd] <= 1 at posedge.
- Simultaneous release and reservation of the same register in one cycle: set wins, so busy stays 1. The register's data still updates with wb_data.
- Writeback to a non-busy register is legal: data is written and busy is unchanged (0).
- pending_cnt = popcount of the next-state busy, registered. Always <= NREGS-1, because x0 is never busy.
- No read latency. Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd_data[i] = wb_data when wb_we && wb_addr!=0 && wb_addr==rd_addr[i].
  - A RAW hazard is resolved by a same-cycle writeback to that register, so there is no stall.
- Not defined:
  - rd_data returns the pre-write register value in the write cycle.
  - RAW stall persists until the cycle after writeback; the bypass term is 0 in raw_i.
  - The WAW release term is unaffected by this macro.

Test Plan:
- Reset flow:
  - Write x5=32'hDEAD_BEEF, reserve x7, then assert rst=0 for one cycle.
  - Required: reads of x5 = 0, busy = 0, pending_cnt = 0.
- x0 handling:
  - wb_we=1, wb_addr=0, wb_data=32'hFFFF_FFFF.
  - Required: rd_data for addr 0 = 0 on all ports.
  - Then issue with iss_rd=0: busy[0] stays 0 and pending_cnt is unchanged.
- RAW hazard:
  - Reserve x3, then issue with rd_addr[0]=3, iss_src_en=2'b01. Required: iss_stall=1.
  - Writeback x3=32'h1234 in the same cycle. With REGFILE_BYPASS_EN: stall=0 and rd_data[0]=32'h1234. Without it: stall=1 this cycle, 0 on the next.
- WAW and simultaneous set/clear:
  - Reserve x9, then issue iss_rd=9 with no writeback. Required: stall=1.
  - Issue iss_rd=9 with writeback x9 in the same cycle. Required: stall=0, busy[9] stays 1, pending_cnt unchanged.
- Counter sweep:
  - Reserve x1..x31 on consecutive cycles. Required: pending_cnt reaches 31.
  - Release all in reverse order. Required: pending_cnt returns to 0, decrementing by 1 per cycle.
- Multi-port reads (NREAD=4):
  - All four ports read x12=32'hA5A5_0F0F in the same cycle as a write to x12 of 32'h0.
  - Required: all four ports agree, showing the old value without bypass and 32'h0 with bypass.
